// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the pending round-robin arbiter.
// Holds the FSM state enum, default sizing and the index-to-one-hot helper.
package pkt_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_MAX_HOLD = 255;
  localparam int MAX_REQ      = 16;

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/pending_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: finds the first set pending bit
// scanning upward from last_idx+1, wrapping modulo NUM_REQ.
module rr_pick
  import pkt_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               found,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  // Scan NUM_REQ positions starting just past the previous grantee.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && pending[(int'(last_idx) + k) % NUM_REQ]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(last_idx) + k) % NUM_REQ);
      end else begin
        found = found;
      end
    end
    onehot = found ? NUM_REQ'(idx_to_onehot(4'(idx))) : '0;
  end

endmodule

// File: rtl/pending_rr_arbiter.sv
// Round-robin arbiter over sticky pending flags with grant held until done.
// Optional grant timeout is compiled in with `define ARB_TIMEOUT_EN.
module pending_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_pulse,
  input  logic [NUM_REQ-1:0] cancel,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] pending,
  output logic               timeout
);

  arb_state_t          state_r;
  logic [IDX_W-1:0]    last_idx_r;
  logic                pick_found_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic [NUM_REQ-1:0]  pick_onehot_s;
  logic                busy_s;
  logic                cancel_grantee_s;
  logic                expire_s;
  logic                release_s;
  logic                timeout_next_s;
  logic [NUM_REQ-1:0]  grantee_oh_s;
  logic [NUM_REQ-1:0]  clr_s;
  logic [NUM_REQ-1:0]  pending_next_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .pending  (pending),
    .last_idx (last_idx_r),
    .found    (pick_found_s),
    .idx      (pick_idx_s),
    .onehot   (pick_onehot_s)
  );

  assign busy_s           = (state_r == ARB_BUSY);
  assign cancel_grantee_s = busy_s && (|(cancel & grant));

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_cnt_r;

  // Hold counter: zero outside BUSY, counts each BUSY cycle until release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_cnt_r <= '0;
    end else if (busy_s && !release_s) begin
      hold_cnt_r <= hold_cnt_r + CNT_W'(1);
    end else begin
      hold_cnt_r <= '0;
    end
  end

  assign expire_s = busy_s && (hold_cnt_r == CNT_W'(MAX_HOLD - 1));
`else
  logic [31:0] unused_hold_s;
  assign unused_hold_s = 32'(MAX_HOLD);
  assign expire_s      = 1'b0;
`endif

  // Release decode and pending-flag next state (set wins over clear).
  always_comb begin
    release_s      = busy_s && (done || cancel_grantee_s || expire_s);
    timeout_next_s = expire_s && !done && !cancel_grantee_s;
    grantee_oh_s   = NUM_REQ'(idx_to_onehot(4'(grant_idx)));
    clr_s          = cancel & ~grant;
    if (release_s) begin
      clr_s = clr_s | grantee_oh_s;
    end else begin
      clr_s = clr_s;
    end
    pending_next_s = (pending & ~clr_s) | req_pulse;
  end

  // FSM, registered grant outputs, pending flags and rotation pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ARB_IDLE;
      pending     <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
      last_idx_r  <= IDX_W'(NUM_REQ - 1);
    end else begin
      pending <= pending_next_s;
      timeout <= timeout_next_s;
      case (state_r)
        ARB_IDLE: begin
          if (pick_found_s) begin
            grant       <= pick_onehot_s;
            grant_idx   <= pick_idx_s;
            grant_valid <= 1'b1;
            state_r     <= ARB_BUSY;
          end else begin
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
          end
        end
        ARB_BUSY: begin
          if (release_s) begin
            last_idx_r  <= grant_idx;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            state_r     <= ARB_IDLE;
          end else begin
            state_r <= ARB_BUSY;
          end
        end
        default: begin
          grant       <= '0;
          grant_idx   <= '0;
          grant_valid <= 1'b0;
          state_r     <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pending_rr_arbiter.md
# pending_rr_arbiter

Round-robin arbiter that shares one downstream packet-filter resource, such as the rule-lookup engine or the output FIFO write port, between NUM_REQ requesters. Each requester raises a one-cycle request pulse that sets a sticky per-requester pending flag. The arbiter grants one pending requester at a time and holds the grant until the resource signals done. On release it clears that requester's pending flag and rotates priority.

## Interface
- NUM_REQ, default 4: number of requesters, 2..16.
- MAX_HOLD, default 255: grant timeout in cycles; used only with ARB_TIMEOUT_EN.
- IDX_W, default $clog2(NUM_REQ): index width; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_pulse  in  NUM_REQ  one-cycle pulse per requester; sets its pending flag.
- cancel  in  NUM_REQ  clears the pending flag of a requester that is not granted.
- done  in  1  the resource has finished with the current grantee.
- grant  out  NUM_REQ  one-hot grant; all zero when idle.
- grant_valid  out  1  OR of grant.
- grant_idx  out  IDX_W  binary index of the grantee; 0 when idle.
- pending  out  NUM_REQ  registered pending flags.
- timeout  out  1  one-cycle pulse when a grant is forcibly released.

## Operation
- pending[i] is a set/clear flag. Set sources: req_pulse[i]. Clear sources: cancel[i] when i is not granted, or release of grantee i.
- Set has priority over clear when both hit the same index in the same cycle.
- FSM states are IDLE and BUSY.
- IDLE:
  - If any pending bit is set, pick the first set bit scanning upward from last_idx+1, wrapping modulo NUM_REQ.
  - Register grant, grant_idx and grant_valid, then go to BUSY.
  - If no pending bit is set, stay in IDLE with outputs zero.
- BUSY:
  - grant is held stable.
  - Release occurs on done, on cancel[grant_idx], or on timeout.
  - On release: clear pending[grant_idx] unless req_pulse[grant_idx] arrives in the same cycle, load last_idx <= grant_idx, deassert grant, and return to IDLE.
- done is ignored in IDLE.
- cancel of the grantee is treated exactly as done.
- After reset, last_idx = NUM_REQ-1, so requester 0 has first priority.
- Reset values: state=IDLE, pending=0, grant=0, grant_valid=0, grant_idx=0, timeout=0, hold counter=0, last_idx=NUM_REQ-1.
- Reset asserted mid-grant drops the grant and clears all pending flags at the next edge; no timeout pulse is issued.

## Timing
- A req_pulse sampled at edge t makes pending visible after edge t. With the FSM in IDLE, grant asserts after edge t+1 (two-cycle request-to-grant latency).
- done sampled at edge t deasserts grant after edge t, while the FSM moves to IDLE. The earliest next grant is after edge t+1.
- One idle bubble always separates consecutive grants, so a requester is never granted on back-to-back cycles.
- The hold counter resets on entry to BUSY and increments each BUSY cycle. The release point is defined in Configuration.
- A requester whose pending flag is already set gains nothing from extra pulses; there is no request counting.

## Configuration
- With ARB_TIMEOUT_EN defined:
  - The hold counter (width $clog2(MAX_HOLD+1)) is compiled in.
  - If MAX_HOLD BUSY cycles elapse without done or cancel, the arbiter releases the grant as if done had arrived and pulses timeout for one cycle, coincident with grant falling.
  - done and timeout in the same cycle count as done; timeout stays 0.
- Without ARB_TIMEOUT_EN:
  - There is no counter.
  - timeout is tied to 0.
  - A grant is held indefinitely until done or cancel.

## Structure
- Package pkt_arb_pkg holds:
  - the arb_state_t enum {ARB_IDLE, ARB_BUSY};
  - the default NUM_REQ and MAX_HOLD constants;
  - an index-to-one-hot helper function.
- One sub-module is natural: rr_pick. It is a purely combinational rotate-priority encoder; inputs are pending and last_idx, outputs are a found flag, the index and the one-hot.
- The FSM, the pending flags and the counter stay in pending_rr_arbiter.

## Test plan
- Reset, then pulse req_pulse=4'b1010 at cycle 0:
  - grant=4'b0010, grant_idx=1 at cycle 2;
  - done at cycle 5, then grant=4'b1000 at cycle 7;
  - pending=0 after the final done.
- All four requesters pending and done issued every grant, repeated for 8 grants: grant_idx sequence is 0,1,2,3,0,1,2,3.
- req_pulse[2] and done in the same cycle while requester 2 is granted: pending[2] stays 1 and requester 2 is regranted after the rotation reaches it again.
- cancel[3] while requester 1 is granted: pending[3] clears and grant stays on 1. Then cancel[1]: grant drops at the next edge with no timeout.
- ARB_TIMEOUT_EN with MAX_HOLD=8, requester 0 granted and no done: timeout pulses once exactly 8 cycles after grant asserts, grant clears, pending[0]=0. Without the macro, the grant is still held at cycle 100.
- reset driven low while in BUSY with pending=4'b1111: the next cycle shows grant=0, pending=0 and state IDLE. After reset releases and requests are pulsed again, the first grant goes to index 0.
